jtag_regfile_chain: RTL and testbench

// - Downstream consumer of the ER1 user chain (JCE1/JTD1) of the JTAGG TAP; replaces a bare LED latch.
// - Shifts fixed-length command frames in over JTDI, decodes them on Update-DR and executes

---
 rtl/jtag_regfile_chain.sv | 132 +++++++++++++
 tb/tb_jtag_regfile_chain.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/jtag_regfile_chain.sv
// ER1 user-chain endpoint: shifts in {data, addr, op} frames, executes WRITE/READ/INC on a small
// register file at Update-DR, and returns {rdata, last_addr, status} on the next Capture-DR.
module jtag_regfile_chain #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic                             JTCK,
    input  logic                             JRSTN,
    input  logic                             JTDI,
    input  logic                             JSHIFT,
    input  logic                             JUPDATE,
    input  logic                             JCE1,
    input  logic                             JRTI1,
    output logic                             JTD1,
    output logic [(2**ADDR_W)*DATA_W-1:0]    regs_flat,
    output logic [7:0]                       op_count
);

    localparam int NREGS   = 2**ADDR_W;
    localparam int FRAME_W = DATA_W + ADDR_W + 2;
    localparam int CNT_W   = $clog2(FRAME_W + 2);

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_INC   = 2'b11;

    logic [FRAME_W-1:0] r_sr;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic               r_sel;
    logic [DATA_W-1:0]  r_rdata;
    logic [DATA_W-1:0]  r_last_data;
    logic [ADDR_W-1:0]  r_last_addr;
    logic [1:0]         r_status;
    logic [1:0]         r_last_op;
    logic [7:0]         r_op_count;
    logic [DATA_W-1:0]  r_regs [NREGS];

    logic [1:0]         w_op;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_data;
    logic               w_update;
    logic               w_full;
    logic               w_repeat;

    // Modulo-2**DATA_W add; the carry is intentionally discarded.
    function automatic logic [DATA_W-1:0] add_wrap(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        return a + b;
    endfunction

    assign w_op     = r_sr[1:0];
    assign w_addr   = r_sr[ADDR_W+1:2];
    assign w_data   = r_sr[FRAME_W-1:ADDR_W+2];
    assign w_update = JUPDATE & r_sel;
    assign w_full   = (r_bit_cnt == CNT_W'(FRAME_W));
    // Any Update-DR cycle, ours or foreign, suppresses the RTI repeat.
    assign w_repeat = JRTI1 & ~JUPDATE & (r_last_op == OP_INC);

    always_ff @(posedge JTCK or negedge JRSTN) begin
        if (!JRSTN) begin
            r_sr        <= '0;
            r_bit_cnt   <= '0;
            r_sel       <= 1'b0;
            r_rdata     <= '0;
            r_last_data <= '0;
            r_last_addr <= '0;
            r_status    <= '0;
            r_last_op   <= OP_NOP;
            r_op_count  <= '0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (JUPDATE) begin
                r_sel <= 1'b0;
            end else if (JCE1) begin
                r_sel <= 1'b1;
            end

            if (JCE1) begin
                if (!JSHIFT) begin
                    r_sr        <= {r_rdata, r_last_addr, r_status};
                    r_bit_cnt   <= '0;
                    r_status[1] <= 1'b0;
                end else begin
                    r_sr <= {JTDI, r_sr[FRAME_W-1:1]};
                    if (r_bit_cnt != CNT_W'(FRAME_W + 1)) begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
            end

            // A frame of the wrong length is flagged and dropped; NOP is accepted but inert.
            if (w_update) begin
                if (!w_full) begin
                    r_status[1] <= 1'b1;
                end else if (w_op != OP_NOP) begin
                    case (w_op)
                        OP_WRITE: begin
                            r_regs[w_addr] <= w_data;
                            r_status[0]    <= 1'b0;
                        end
                        OP_READ: begin
                            r_rdata     <= r_regs[w_addr];
                            r_status[0] <= 1'b1;
                        end
                        default: begin
                            r_regs[w_addr] <= add_wrap(r_regs[w_addr], w_data);
                            r_status[0]    <= 1'b0;
                        end
                    endcase
                    r_last_addr <= w_addr;
                    r_last_data <= w_data;
                    r_last_op   <= w_op;
                    r_op_count  <= r_op_count + 8'd1;
                end
            end else if (w_repeat) begin
                r_regs[r_last_addr] <= add_wrap(r_regs[r_last_addr], r_last_data);
                r_op_count          <= r_op_count + 8'd1;
            end
        end
    end

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_flat
        assign regs_flat[gi*DATA_W +: DATA_W] = r_regs[gi];
    end

    assign JTD1     = r_sr[0];
    assign op_count = r_op_count;

endmodule

// File: tb/tb_jtag_regfile_chain.sv
// Scoreboard bench for jtag_regfile_chain: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them against the live DUT outputs.
module tb_jtag_regfile_chain;

    logic         JTCK = 1'b0;
    logic         JRSTN, JTDI, JSHIFT, JUPDATE, JCE1, JRTI1;
    logic         JTD1;
    logic [127:0] regs_flat;
    logic [7:0]   op_count;

    jtag_regfile_chain #(.DATA_W(16), .ADDR_W(3)) dut (
        .JTCK(JTCK), .JRSTN(JRSTN), .JTDI(JTDI), .JSHIFT(JSHIFT), .JUPDATE(JUPDATE),
        .JCE1(JCE1), .JRTI1(JRTI1), .JTD1(JTD1), .regs_flat(regs_flat), .op_count(op_count)
    );

    always #5 JTCK = ~JTCK;

    int cyc = 0;
    always @(posedge JTCK) cyc <= cyc + 1;

    int           q_at[$];
    int           q_kind[$];
    int           q_idx[$];
    logic [127:0] q_exp[$];
    string        q_name[$];

    int n_checks = 0;
    int n_fail   = 0;

    int           m_at, m_kind, m_idx;
    logic [127:0] m_exp, m_act;
    string        m_nm;

    // kind 0: JTD1, 1: op_count, 2: full regs_flat, 3: one register
    task automatic expect_v(input int kind, input int idx, input logic [127:0] val, input string nm);
        q_at.push_back(cyc);
        q_kind.push_back(kind);
        q_idx.push_back(idx);
        q_exp.push_back(val);
        q_name.push_back(nm);
    endtask

    task automatic chk_reg(input int i, input logic [15:0] v, input string nm);
        expect_v(3, i, {112'b0, v}, nm);
    endtask

    task automatic chk_opc(input logic [7:0] v, input string nm);
        expect_v(1, 0, {120'b0, v}, nm);
    endtask

    always @(negedge JTCK) begin
        while (q_at.size() > 0 && q_at[0] <= cyc) begin
            m_at   = q_at.pop_front();
            m_kind = q_kind.pop_front();
            m_idx  = q_idx.pop_front();
            m_exp  = q_exp.pop_front();
            m_nm   = q_name.pop_front();
            n_checks++;
            if (m_at != cyc) begin
                n_fail++;
                $display("FAIL %s: not checked at cycle %0d (now %0d)", m_nm, m_at, cyc);
            end else begin
                case (m_kind)
                    0:       m_act = {127'b0, JTD1};
                    1:       m_act = {120'b0, op_count};
                    2:       m_act = regs_flat;
                    default: m_act = {112'b0, regs_flat[m_idx*16 +: 16]};
                endcase
                if (m_act !== m_exp) begin
                    n_fail++;
                    $display("FAIL %s: got %0h expected %0h", m_nm, m_act, m_exp);
                end
            end
        end
    end

    function automatic logic [20:0] fr(input logic [1:0] op, input logic [2:0] a, input logic [15:0] d);
        return {d, a, op};
    endfunction

    task automatic step();
        @(posedge JTCK);
        #1;
    endtask

    task automatic capture();
        JCE1 = 1'b1; JSHIFT = 1'b0;
        step();
    endtask

    task automatic shift(input logic [20:0] din, input int nbits, input logic [20:0] exp_out, input string nm);
        for (int k = 0; k < nbits; k++) begin
            expect_v(0, 0, {127'b0, exp_out[k]}, $sformatf("%s_tdo%0d", nm, k));
            JCE1 = 1'b1; JSHIFT = 1'b1; JTDI = din[k];
            step();
        end
        JCE1 = 1'b0; JSHIFT = 1'b0; JTDI = 1'b0;
    endtask

    task automatic update(input logic rti);
        JUPDATE = 1'b1; JRTI1 = rti;
        step();
        JUPDATE = 1'b0; JRTI1 = 1'b0;
    endtask

    logic [15:0] rti_exp [4] = '{16'h0004, 16'h0007, 16'h000A, 16'h000D};

    initial begin
        JRSTN = 1'b0; JTDI = 1'b0; JSHIFT = 1'b0; JUPDATE = 1'b0; JCE1 = 1'b0; JRTI1 = 1'b0;
        step(); step();
        expect_v(2, 0, 128'h0, "rst_regs");
        chk_opc(8'd0, "rst_opc");
        expect_v(0, 0, 128'h0, "rst_tdo");
        step();
        JRSTN = 1'b1;
        step();

        // Zero capture stream, then a NOP frame
        capture();
        shift(21'h0, 21, 21'h0, "zero");
        update(1'b0);
        chk_opc(8'd0, "nop_opc");
        expect_v(2, 0, 128'h0, "nop_regs");

        // WRITE reg5
        capture();
        shift(fr(2'b01, 3'd5, 16'hA5C3), 21, 21'h0, "wr_out");
        update(1'b0);
        expect_v(2, 0, 128'hA5C3 << 80, "wr_flat");
        chk_reg(5, 16'hA5C3, "wr_reg5");
        chk_opc(8'd1, "wr_opc");

        // READ reg5 and scan the result back out
        capture();
        shift(fr(2'b10, 3'd5, 16'h0), 21, fr(2'b00, 3'd5, 16'h0), "rd_pre");
        update(1'b0);
        chk_opc(8'd2, "rd_opc");
        capture();
        shift(21'h0, 21, fr(2'b01, 3'd5, 16'hA5C3), "rd_out");
        update(1'b0);
        chk_opc(8'd2, "nop2_opc");

        // INC wrap and RTI repeats
        capture();
        shift(fr(2'b01, 3'd2, 16'hFFFE), 21, fr(2'b01, 3'd5, 16'hA5C3), "wr2");
        update(1'b0);
        chk_reg(2, 16'hFFFE, "wr2_reg");
        chk_opc(8'd3, "wr2_opc");
        capture();
        shift(fr(2'b11, 3'd2, 16'h0003), 21, fr(2'b00, 3'd2, 16'hA5C3), "inc");
        update(1'b0);
        chk_reg(2, 16'h0001, "inc_wrap");
        chk_opc(8'd4, "inc_opc");
        for (int i = 0; i < 4; i++) begin
            JRTI1 = 1'b1;
            step();
            chk_reg(2, rti_exp[i], $sformatf("rti%0d_reg2", i));
        end
        JRTI1 = 1'b0;
        chk_opc(8'd8, "rti_opc");
        chk_reg(5, 16'hA5C3, "rti_keep5");
        step();

        // Short frame: rejected, overrun flag seen once then cleared
        capture();
        shift(fr(2'b01, 3'd0, 16'h1234), 20, fr(2'b00, 3'd2, 16'hA5C3), "short");
        update(1'b0);
        chk_reg(0, 16'h0000, "short_reg0");
        chk_opc(8'd8, "short_opc");
        capture();
        shift(21'h0, 21, fr(2'b10, 3'd2, 16'hA5C3), "ovr1");
        update(1'b0);
        capture();
        shift(21'h0, 21, fr(2'b00, 3'd2, 16'hA5C3), "ovr0");
        update(1'b0);

        // Foreign update leaves a valid INC frame unexecuted
        capture();
        shift(fr(2'b11, 3'd1, 16'h0010), 21, fr(2'b00, 3'd2, 16'hA5C3), "inc1");
        update(1'b0);
        chk_reg(1, 16'h0010, "inc1_reg1");
        chk_opc(8'd9, "inc1_opc");
        step();
        update(1'b0);
        chk_reg(1, 16'h0010, "foreign_reg1");
        chk_opc(8'd9, "foreign_opc");

        // Update and RTI together: update only, then RTI after WRITE does nothing
        capture();
        shift(fr(2'b01, 3'd1, 16'h0777), 21, fr(2'b00, 3'd1, 16'hA5C3), "wr1");
        update(1'b1);
        chk_reg(1, 16'h0777, "updrti_reg1");
        chk_opc(8'd10, "updrti_opc");
        JRTI1 = 1'b1;
        step();
        JRTI1 = 1'b0;
        chk_reg(1, 16'h0777, "rti_after_wr");
        chk_opc(8'd10, "rti_after_wr_opc");

        // Reset mid-shift discards everything
        capture();
        shift(fr(2'b11, 3'd3, 16'h0001), 10, fr(2'b00, 3'd1, 16'hA5C3), "partial");
        JRSTN = 1'b0;
        #1;
        expect_v(2, 0, 128'h0, "midrst_regs");
        chk_opc(8'd0, "midrst_opc");
        expect_v(0, 0, 128'h0, "midrst_tdo");
        step();
        JRSTN = 1'b1;
        update(1'b0);
        chk_opc(8'd0, "post_rst_opc");
        expect_v(2, 0, 128'h0, "post_rst_regs");

        step(); step(); step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
